i2c_slave_regfile: RTL and testbench
====================================

// Module: i2c_slave_regfile
// PURPOSE
//   System-clock I2C target with an internal NUM_REGS x 8 register file and auto-incrementing pointer.
//   SCL/SDA are oversampled on clk; START, STOP and repeated START are detected; SDA is open-drain (drive-low enable only).
//   Sits between board-level I2C pins and local control logic, which gets a host read/write port and a write strobe.
// PARAMETERS
//   NUM_REGS     16     number of 8-bit registers; 2..256; PTR_W = $clog2(NUM_REGS)
//   SYNC_STAGES  2      flops in the SCL/SDA input synchroniser; >=2
//   RESET_VAL    8'h00  reset value of every register
// PORTS
//   clk          in   1      system clock; must be >= 16x SCL frequency
//   rst          in   1      asynchronous, active-high reset
//   own_addr     in   7      7-bit target address; sampled at each address-byte compare
//   scl_i        in   1      SCL pin input
//   sda_i        in   1      SDA pin input
//   sda_oe       out  1      1 = pull SDA low; 0 = release (pad is open-drain)
//   host_we      in   1      host write enable
//   host_addr    in   PTR_W  host read/write register index
//   host_wdata   in   8      host write data
//   host_rdata   out  8      combinational read of reg[host_addr]
//   i2c_wr_stb   out  1      1-clk pulse when an I2C data byte is committed to a register
//   i2c_wr_addr  out  PTR_W  index of the committed register (held until next strobe)
//   i2c_wr_data  out  8      committed byte (held until next strobe)
//   busy         out  1      1 from an addressed START (address matched) until STOP
// BEHAVIOUR
//   Reset: sda_oe=0, i2c_wr_stb=0, i2c_wr_addr=0, i2c_wr_data=0, busy=0, ptr=0, all regs=RESET_VAL, state=IDLE.
//   Input path: SYNC_STAGES-flop synchroniser, then one edge-detect flop; pin-to-action latency = SYNC_STAGES+1 clk.
//   Detect: START = SDA fall while SCL high; STOP = SDA rise while SCL high; SDA sampled on SCL rise; SDA output changes only on SCL fall.
//   Bits are MSB first; the bit counter counts 7..0.
//   FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
//   IDLE -START-> ADDR. After 8 bits, compare [7:1] with own_addr:
//     - mismatch -> WAIT_STOP, never drive SDA;
//     - match -> ADDR_ACK: sda_oe=1 from the SCL fall after bit 0 to the next SCL fall; busy=1.
//   ADDR_ACK exit: R/W=0 -> PTR; R/W=1 -> RDATA.
//   PTR: 8 bits received.
//     - byte < NUM_REGS -> ptr=byte, ACK, then WDATA;
//     - byte >= NUM_REGS -> NACK (SDA released), WAIT_STOP, ptr unchanged.
//   WDATA: 8 bits received, then in the same clk: reg[ptr]=byte, i2c_wr_stb=1, i2c_wr_addr=ptr, i2c_wr_data=byte,
//     ptr=(ptr+1) mod NUM_REGS (NUM_REGS-1 wraps to 0); ACK; back to WDATA.
//   RDATA: shift register loaded with reg[ptr] at the SCL fall that ends the ACK; sda_oe=~bit on each SCL fall; ptr increments with wrap after the load.
//   RDATA_ACK: SDA released; master bit sampled on SCL rise.
//     - 0 (ACK) -> RDATA with next register;
//     - 1 (NACK) -> WAIT_STOP.
//   START in any state, including mid-byte (repeated START): abort current byte, no commit, sda_oe=0, -> ADDR; ptr retained.
//   STOP in any state -> IDLE, sda_oe=0, busy=0; ptr retained; partial byte discarded.
//   Same-clk host_we and I2C commit to the same register: I2C commit wins; to different registers both complete.
//   A host write lands before the next RDATA load if it occurs >=1 clk earlier.
//   rst asserted mid-transfer: immediate return to reset values; SDA released asynchronously.
//   Clock stretching is not supported; general-call and 10-bit addressing are ignored (treated as mismatch).
// STRUCTURE
//   i2c_pkg (shared): state enum, I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RW_WRITE=1'b0, I2C_RW_READ=1'b1.
//   Sub-module i2c_sync_edge: synchroniser + edge detect; outputs scl_rise, scl_fall, start_det, stop_det, sda_s.
//   Top level: FSM, bit counter, shift register, pointer, register array.
// TESTING
//   1. own_addr=7'h42, write 0x84,0x03,0xAA,0xBB, STOP -> ACK on all 4 bytes; reg[3]=AA, reg[4]=BB; two i2c_wr_stb pulses; busy 1->0.
//   2. Then 0x84,0x03, rSTART, 0x85, read 2 bytes (ACK then NACK), STOP -> SDA returns AA,BB; no further drive after NACK.
//   3. NUM_REGS=16: write 0x84,0x0F,0x11,0x22 -> reg[15]=11, reg[0]=22; pointer 0x10 -> NACK, no strobe.
//   4. Address 0x86 (mismatch) -> sda_oe stays 0 for the whole transfer; busy=0; no register change.
//   5. host_we to reg[5] in the same clk as I2C commit to reg[5] -> I2C value stored; host_we to reg[6] then read via I2C -> host value.
//   6. rst pulse mid-WDATA bit 4 -> sda_oe=0 within 0 clk, regs=RESET_VAL; next START+0x84 ACKed normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C register-file target.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// SCL/SDA synchroniser plus one edge-detect stage; produces bus events for the target FSM.
`timescale 1ns/1ps
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-high bus level so releasing reset creates no false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with an auto-incrementing pointer into a NUM_REGS x 8 register file and a host port.
`timescale 1ns/1ps
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       own_addr,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             i2c_wr_stb,
  output logic [PTR_W-1:0] i2c_wr_addr,
  output logic [7:0]       i2c_wr_data,
  output logic             busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl_i),
    .sda       (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_t             state, state_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic               phase, phase_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, ptr_inc;
  logic               oe_nxt, busy_nxt, commit, rd_load;
  logic [7:0]         regs [NUM_REGS];
  logic [7:0]         rx_byte, rd_byte;
  logic               last_bit, addr_match, ptr_ok, host_ok;

  assign rx_byte    = {shreg[6:0], sda_s};
  assign last_bit   = (bit_cnt == 3'd0);
  // General call (0) and the 10-bit prefix 11110xx never match.
  assign addr_match = (rx_byte[7:1] == own_addr) && (rx_byte[7:1] != 7'd0) &&
                      (rx_byte[7:3] != 5'b11110);
  assign ptr_ok     = int'(rx_byte) < NUM_REGS;
  assign ptr_inc    = (int'(ptr) == NUM_REGS - 1) ? '0 : ptr + PTR_W'(1);
  assign rd_byte    = regs[ptr];

  if (NUM_REGS == (1 << PTR_W)) begin : g_pow2
    assign host_ok = 1'b1;
  end else begin : g_npow2
    assign host_ok = int'(host_addr) < NUM_REGS;
  end

  assign host_rdata = host_ok ? regs[host_addr] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // phase marks the second half of an ACK slot (or the post-byte release in RDATA).
  always_comb begin
    state_nxt = state;
    if (stop_det)       state_nxt = IDLE;
    else if (start_det) state_nxt = ADDR;
    else begin
      case (state)
        ADDR:      if (scl_rise && last_bit) state_nxt = addr_match ? ADDR_ACK : WAIT_STOP;
        PTR:       if (scl_rise && last_bit) state_nxt = ptr_ok ? PTR_ACK : WAIT_STOP;
        WDATA:     if (scl_rise && last_bit) state_nxt = WDATA_ACK;
        ADDR_ACK:  if (scl_fall && phase) state_nxt = (shreg[0] == I2C_RW_READ) ? RDATA : PTR;
        PTR_ACK,
        WDATA_ACK: if (scl_fall && phase) state_nxt = WDATA;
        RDATA:     if (scl_fall && phase) state_nxt = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && !phase && sda_s == I2C_NACK) state_nxt = WAIT_STOP;
          else if (scl_fall && phase)                  state_nxt = RDATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    phase_nxt   = phase;
    oe_nxt      = sda_oe;
    busy_nxt    = busy;
    ptr_nxt     = ptr;
    commit      = 1'b0;
    rd_load     = 1'b0;
    if (stop_det) begin
      oe_nxt   = 1'b0;
      busy_nxt = 1'b0;
    end else if (start_det) begin
      oe_nxt      = 1'b0;
      bit_cnt_nxt = 3'd7;
      phase_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: if (scl_rise) begin
          shreg_nxt   = rx_byte;
          bit_cnt_nxt = bit_cnt - 3'd1;
          if (last_bit) begin
            phase_nxt = 1'b0;
            if (state == ADDR && addr_match) busy_nxt = 1'b1;
            if (state == PTR && ptr_ok)      ptr_nxt  = rx_byte[PTR_W-1:0];
            if (state == WDATA) begin
              commit  = 1'b1;
              ptr_nxt = ptr_inc;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_nxt    = 1'b1;
            phase_nxt = 1'b1;
          end else begin
            oe_nxt      = 1'b0;
            phase_nxt   = 1'b0;
            bit_cnt_nxt = 3'd7;
            if (state == ADDR_ACK && shreg[0] == I2C_RW_READ) rd_load = 1'b1;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            if (last_bit) phase_nxt   = 1'b1;
            else          bit_cnt_nxt = bit_cnt - 3'd1;
          end
          if (scl_fall) begin
            if (phase) begin
              oe_nxt    = 1'b0;
              phase_nxt = 1'b0;
            end else begin
              oe_nxt    = ~shreg[6];
              shreg_nxt = {shreg[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && !phase && sda_s == I2C_ACK) phase_nxt = 1'b1;
          if (scl_fall && phase)                      rd_load   = 1'b1;
        end
        default: ;
      endcase
    end
    if (rd_load) begin
      shreg_nxt   = rd_byte;
      oe_nxt      = ~rd_byte[7];
      ptr_nxt     = ptr_inc;
      bit_cnt_nxt = 3'd7;
      phase_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= 8'h00;
      bit_cnt     <= 3'd7;
      phase       <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      ptr         <= '0;
      i2c_wr_stb  <= 1'b0;
      i2c_wr_addr <= '0;
      i2c_wr_data <= 8'h00;
    end else begin
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      phase      <= phase_nxt;
      sda_oe     <= oe_nxt;
      busy       <= busy_nxt;
      ptr        <= ptr_nxt;
      i2c_wr_stb <= commit;
      if (commit) begin
        i2c_wr_addr <= ptr;
        i2c_wr_data <= rx_byte;
      end
    end
  end

  // The I2C commit is written last so it wins a same-register collision with the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      if (host_we && host_ok) regs[host_addr] <= host_wdata;
      if (commit)             regs[ptr]       <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed and randomized I2C master traffic against a register-array reference model.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int Q        = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] own_addr;
  logic       scl_m, sda_m, sda_bus, sda_oe;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       i2c_wr_stb;
  logic [3:0] i2c_wr_addr;
  logic [7:0] i2c_wr_data;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int stb_cnt = 0;
  int oe_cnt  = 0;

  logic [7:0] exp_regs [NUM_REGS];
  int         exp_ptr;
  logic [7:0] exp_q[$];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .own_addr    (own_addr),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .i2c_wr_stb  (i2c_wr_stb),
    .i2c_wr_addr (i2c_wr_addr),
    .i2c_wr_data (i2c_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i2c_wr_stb) stb_cnt++;
    if (sda_oe)     oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  // hit pulses host_we so it is sampled on the clk where the SCL rise takes effect.
  task automatic write_bit(input logic b, input logic hit);
    sda_m = b;
    q_wait();
    scl_m = 1'b1;
    if (hit) begin
      repeat (2) @(posedge clk);
      #1 host_we = 1'b1;
      @(posedge clk);
      #1 host_we = 1'b0;
    end
    q_wait();
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    q_wait();
    scl_m = 1'b1;
    q_wait();
    b = sda_bus;
    q_wait();
    scl_m = 1'b0;
    q_wait();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q_wait();
    scl_m = 1'b1; q_wait();
    sda_m = 1'b1; q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack, input logic hit);
    for (int i = 7; i >= 0; i--) write_bit(d[i], hit && (i == 0));
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack, 1'b0);
  endtask

  task automatic wr_acked(input string tag, input logic [7:0] d);
    logic ack;
    write_byte(d, ack, 1'b0);
    check(tag, 32'(ack), 32'(I2C_ACK));
  endtask

  task automatic check_reg(input string tag, input int a);
    host_addr = 4'(a);
    #1 check(tag, 32'(host_rdata), 32'(exp_regs[a]));
  endtask

  task automatic model_write(input logic [7:0] d);
    exp_regs[exp_ptr] = d;
    exp_ptr = (exp_ptr + 1) % NUM_REGS;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
    exp_ptr = 0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         s0, o0, p, n;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0; own_addr = 7'h42;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stb", 32'(i2c_wr_stb), 32'd0);
    check("rst_wr_addr", 32'(i2c_wr_addr), 32'd0);
    check("rst_wr_data", 32'(i2c_wr_data), 32'd0);
    check_reg("rst_reg7", 7);
    rst = 1'b0;
    q_wait();

    // Basic write of two data bytes from pointer 3.
    s0 = stb_cnt;
    i2c_start();
    wr_acked("t1_addr_ack", 8'h84);
    wr_acked("t1_ptr_ack", 8'h03);
    exp_ptr = 3;
    check("t1_busy_high", 32'(busy), 32'd1);
    wr_acked("t1_d0_ack", 8'hAA); model_write(8'hAA);
    wr_acked("t1_d1_ack", 8'hBB); model_write(8'hBB);
    i2c_stop(); q_wait();
    check("t1_stb_count", 32'(stb_cnt - s0), 32'd2);
    check("t1_wr_addr", 32'(i2c_wr_addr), 32'd4);
    check("t1_wr_data", 32'(i2c_wr_data), 32'hBB);
    check("t1_busy_low", 32'(busy), 32'd0);
    check_reg("t1_reg3", 3);
    check_reg("t1_reg4", 4);

    // Pointer set, repeated START, read two bytes.
    i2c_start();
    wr_acked("t2_addr_ack", 8'h84);
    wr_acked("t2_ptr_ack", 8'h03);
    exp_ptr = 3;
    i2c_start();
    wr_acked("t2_raddr_ack", 8'h85);
    read_byte(d, I2C_ACK);
    check("t2_rd0", 32'(d), 32'(exp_regs[exp_ptr])); exp_ptr = (exp_ptr + 1) % NUM_REGS;
    read_byte(d, I2C_NACK);
    check("t2_rd1", 32'(d), 32'(exp_regs[exp_ptr])); exp_ptr = (exp_ptr + 1) % NUM_REGS;
    o0 = oe_cnt;
    q_wait(); q_wait();
    i2c_stop(); q_wait();
    check("t2_no_drive_after_nack", 32'(oe_cnt - o0), 32'd0);

    // Pointer wrap, then out-of-range pointer is NACKed and leaves the pointer alone.
    i2c_start();
    wr_acked("t3_addr_ack", 8'h84);
    wr_acked("t3_ptr_ack", 8'h0F);
    exp_ptr = 15;
    wr_acked("t3_d0_ack", 8'h11); model_write(8'h11);
    wr_acked("t3_d1_ack", 8'h22); model_write(8'h22);
    i2c_stop(); q_wait();
    check_reg("t3_reg15", 15);
    check_reg("t3_reg0", 0);
    s0 = stb_cnt;
    i2c_start();
    wr_acked("t3_addr2_ack", 8'h84);
    write_byte(8'h10, ack, 1'b0);
    check("t3_ptr_nack", 32'(ack), 32'(I2C_NACK));
    i2c_stop(); q_wait();
    check("t3_no_stb", 32'(stb_cnt - s0), 32'd0);
    i2c_start();
    wr_acked("t3_raddr_ack", 8'h85);
    read_byte(d, I2C_NACK);
    check("t3_ptr_kept", 32'(d), 32'(exp_regs[exp_ptr])); exp_ptr = (exp_ptr + 1) % NUM_REGS;
    i2c_stop(); q_wait();

    // Address mismatch: never drive, never write.
    o0 = oe_cnt; s0 = stb_cnt;
    i2c_start();
    write_byte(8'h86, ack, 1'b0); check("t4_addr_nack", 32'(ack), 32'(I2C_NACK));
    write_byte(8'h03, ack, 1'b0); check("t4_ptr_nack", 32'(ack), 32'(I2C_NACK));
    write_byte(8'h55, ack, 1'b0); check("t4_data_nack", 32'(ack), 32'(I2C_NACK));
    check("t4_busy", 32'(busy), 32'd0);
    i2c_stop(); q_wait();
    check("t4_no_drive", 32'(oe_cnt - o0), 32'd0);
    check("t4_no_stb", 32'(stb_cnt - s0), 32'd0);
    check_reg("t4_reg3", 3);

    // Host/I2C collision on reg 5, then host write to reg 6 read back over I2C.
    i2c_start();
    wr_acked("t5_addr_ack", 8'h84);
    wr_acked("t5_ptr_ack", 8'h05);
    exp_ptr = 5;
    host_addr = 4'd5; host_wdata = 8'hC3;
    write_byte(8'h5A, ack, 1'b1);
    check("t5_d_ack", 32'(ack), 32'(I2C_ACK));
    model_write(8'h5A);
    i2c_stop(); q_wait();
    check("t5_wr_addr", 32'(i2c_wr_addr), 32'd5);
    check_reg("t5_reg5_i2c_wins", 5);
    host_addr = 4'd6; host_wdata = 8'h77; host_we = 1'b1;
    @(negedge clk); host_we = 1'b0;
    exp_regs[6] = 8'h77;
    i2c_start();
    wr_acked("t5_addr2_ack", 8'h84);
    wr_acked("t5_ptr2_ack", 8'h06);
    exp_ptr = 6;
    i2c_start();
    wr_acked("t5_raddr_ack", 8'h85);
    read_byte(d, I2C_NACK);
    check("t5_host_val", 32'(d), 32'(exp_regs[exp_ptr])); exp_ptr = (exp_ptr + 1) % NUM_REGS;
    i2c_stop(); q_wait();

    // Reset while the target is pulling SDA low for an address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h84 >> i), 1'b0);
    sda_m = 1'b1;
    q_wait();
    check("t6_ack_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1 check("t6_async_release", 32'(sda_oe), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    model_reset();
    scl_m = 1'b1; sda_m = 1'b1;
    q_wait(); rst = 1'b0; q_wait();

    // Rewrite some registers, then reset in the middle of WDATA bit 4.
    i2c_start();
    wr_acked("t6_addr_ack", 8'h84);
    wr_acked("t6_ptr_ack", 8'h0F);
    exp_ptr = 15;
    wr_acked("t6_d0_ack", 8'h99); model_write(8'h99);
    write_bit(1'b0, 1'b0); write_bit(1'b0, 1'b1 & 1'b0); write_bit(1'b1, 1'b0);
    sda_m = 1'b1; q_wait(); scl_m = 1'b1; q_wait();
    rst = 1'b1;
    #1 check("t6_mid_sda_oe", 32'(sda_oe), 32'd0);
    check("t6_mid_stb", 32'(i2c_wr_stb), 32'd0);
    model_reset();
    check_reg("t6_reg15_reset", 15);
    check_reg("t6_reg3_reset", 3);
    sda_m = 1'b1;
    q_wait(); rst = 1'b0; q_wait();
    i2c_start();
    wr_acked("t6_after_rst_ack", 8'h84);
    i2c_stop(); q_wait();

    // Randomized bursts: write, optional host write, read back through I2C.
    for (int t = 0; t < 8; t++) begin
      p = int'($urandom_range(0, NUM_REGS - 1));
      n = int'($urandom_range(1, 4));
      s0 = stb_cnt;
      i2c_start();
      wr_acked("rnd_addr_ack", 8'h84);
      wr_acked("rnd_ptr_ack", 8'(p));
      exp_ptr = p;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom_range(0, 255));
        wr_acked("rnd_data_ack", d);
        model_write(d);
      end
      i2c_stop(); q_wait();
      check("rnd_stb_count", 32'(stb_cnt - s0), 32'(n));
      check("rnd_wr_data", 32'(i2c_wr_data), 32'(d));
      if ($urandom_range(0, 1) == 1) begin
        host_addr = 4'($urandom_range(0, NUM_REGS - 1));
        host_wdata = 8'($urandom_range(0, 255));
        host_we = 1'b1;
        exp_regs[host_addr] = host_wdata;
        @(negedge clk); host_we = 1'b0;
      end
      i2c_start();
      wr_acked("rnd_addr2_ack", 8'h84);
      wr_acked("rnd_ptr2_ack", 8'(p));
      i2c_start();
      wr_acked("rnd_raddr_ack", 8'h85);
      exp_ptr = p;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(exp_regs[exp_ptr]);
        exp_ptr = (exp_ptr + 1) % NUM_REGS;
      end
      for (int k = 0; k < n; k++) begin
        read_byte(d, (k == n - 1) ? I2C_NACK : I2C_ACK);
        check("rnd_read", 32'(d), 32'(exp_q.pop_front()));
      end
      i2c_stop(); q_wait();
      check_reg("rnd_host_view", p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
